// File: rtl/integrator_gen2_pkg.sv
// Shared types and constants for the heading PID datapath.
package pid_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2
    } integ_state_t;

    localparam int SAT_HOLD  = 0;
    localparam int SAT_CLAMP = 1;

endpackage

// File: rtl/integrator_gen2_if.sv
// Sample/result bundle between the error saturator, integrator and PID summer.
interface integrator_gen2_if #(
    parameter int ERR_W = 10,
    parameter int OUT_W = 12
);
    logic                    moving;
    logic                    hdng_vld;
    logic                    clr;
    logic signed [ERR_W-1:0] err_sat;
    logic signed [OUT_W-1:0] I_term;
    logic                    I_vld;
    logic                    sat;

    // Upstream side: supplies samples and control, consumes the integral term.
    modport master (
        output moving, hdng_vld, clr, err_sat,
        input  I_term, I_vld, sat
    );

    // Integrator side.
    modport slave (
        input  moving, hdng_vld, clr, err_sat,
        output I_term, I_vld, sat
    );
endinterface

// File: rtl/integrator_gen2_sat_add.sv
// Signed add with overflow detect and hold/clamp result select.
// Purely combinational so the derivative path can share it.
module sat_add
    import pid_pkg::*;
#(
    parameter int IN_W  = 10,
    parameter int ACC_W = 16,
    parameter int MODE  = SAT_HOLD
) (
    input  logic signed [IN_W-1:0]  i_a,
    input  logic signed [ACC_W-1:0] i_b,
    output logic signed [ACC_W-1:0] o_sum,
    output logic                    o_ov
);
    // One guard bit is enough: |a| is always smaller than the accumulator range.
    logic signed [ACC_W:0] w_s;

    assign w_s  = {{(ACC_W + 1 - IN_W){i_a[IN_W-1]}}, i_a} + {i_b[ACC_W-1], i_b};
    assign o_ov = w_s[ACC_W] ^ w_s[ACC_W-1];

    // Choose wrapped sum, held old value or the rail matching the true sign.
    always_comb begin
        o_sum = w_s[ACC_W-1:0];
        if (o_ov) begin
            if (MODE == SAT_CLAMP) begin
                o_sum = w_s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                   : {1'b0, {(ACC_W-1){1'b1}}};
            end else begin
                o_sum = i_b;
            end
        end
    end
endmodule

// File: rtl/integrator_gen2.sv
// Integral-term accumulator for the heading PID controller: settle window
// after motion starts, hold/clamp overflow policy, periodic leak, sync clear.
module integrator_gen2
    import pid_pkg::*;
#(
    parameter int ERR_W       = 10,
    parameter int ACC_W       = 16,
    parameter int OUT_W       = 12,
    parameter int SAT_MODE    = SAT_HOLD,
    parameter int LEAK_SHIFT  = 0,
    parameter int LEAK_PERIOD = 64,
    parameter int SETTLE      = 8
) (
    input logic               clk,
    input logic               rst,
    integrator_gen2_if.slave  bus
);
    localparam int LC_W = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;
    localparam int ST_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    integ_state_t            r_state;
    logic signed [ACC_W-1:0] r_acc;
    logic [LC_W-1:0]         r_leak_cnt;
    logic [ST_W-1:0]         r_settle_cnt;
    logic                    r_sat;
    logic                    r_i_vld;

    logic signed [ACC_W-1:0] w_v;
    logic                    w_ov;
    logic signed [ACC_W-1:0] w_leak;
    logic                    w_leak_due;
    logic                    w_accept;

    sat_add #(
        .IN_W  (ERR_W),
        .ACC_W (ACC_W),
        .MODE  (SAT_MODE)
    ) u_sat_add (
        .i_a   (bus.err_sat),
        .i_b   (r_acc),
        .o_sum (w_v),
        .o_ov  (w_ov)
    );

    // Leak acts on the post-overflow value; v - (v>>>k) stays in range and
    // drives -1 to 0 because the arithmetic shift of -1 is -1.
    assign w_leak     = w_v - (w_v >>> LEAK_SHIFT);
    assign w_leak_due = (LEAK_SHIFT > 0) && (r_leak_cnt == LC_W'(LEAK_PERIOD - 1));
    assign w_accept   = (r_state == pid_pkg::RUN) && bus.hdng_vld && !bus.clr;

    // FSM, counters and accumulator; priority rst > !moving > clr > sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= pid_pkg::IDLE;
            r_acc        <= '0;
            r_leak_cnt   <= '0;
            r_settle_cnt <= '0;
            r_sat        <= 1'b0;
            r_i_vld      <= 1'b0;
        end else if (!bus.moving) begin
            r_state      <= pid_pkg::IDLE;
            r_acc        <= '0;
            r_leak_cnt   <= '0;
            r_settle_cnt <= '0;
            r_sat        <= 1'b0;
            r_i_vld      <= 1'b0;
        end else begin
            case (r_state)
                pid_pkg::IDLE: begin
                    r_settle_cnt <= '0;
                    r_state      <= (SETTLE == 0) ? pid_pkg::RUN : pid_pkg::SETTLE;
                end
                pid_pkg::SETTLE: begin
                    if (r_settle_cnt == ST_W'(SETTLE - 1)) begin
                        r_state <= pid_pkg::RUN;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + ST_W'(1);
                    end
                end
                pid_pkg::RUN: r_state <= pid_pkg::RUN;
                default:      r_state <= pid_pkg::IDLE;
            endcase

            if (bus.clr) begin
                r_acc      <= '0;
                r_leak_cnt <= '0;
                r_sat      <= 1'b0;
                r_i_vld    <= 1'b0;
            end else if (w_accept) begin
                r_acc   <= w_leak_due ? w_leak : w_v;
                r_sat   <= w_ov;
                r_i_vld <= 1'b1;
                if (LEAK_SHIFT > 0) begin
                    r_leak_cnt <= w_leak_due ? '0 : r_leak_cnt + LC_W'(1);
                end
            end else begin
                r_i_vld <= 1'b0;
            end
        end
    end

    assign bus.I_term = r_acc[ACC_W-1 -: OUT_W];
    assign bus.I_vld  = r_i_vld;
    assign bus.sat    = r_sat;

endmodule

// File: tb/tb_integrator_gen2.sv
// Directed bench for integrator_gen2: hold, clamp and leak variants side by side.
module tb_integrator_gen2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Shared drive for the hold (dut0) and clamp (dut1) instances.
    logic       d_mv, d_vld, d_clr;
    logic [9:0] d_err;
    // Drive for the leak instance (dut2).
    logic       e_mv, e_vld, e_clr;
    logic [9:0] e_err;

    integrator_gen2_if bus0 ();
    integrator_gen2_if bus1 ();
    integrator_gen2_if bus2 ();

    assign bus0.moving = d_mv;  assign bus0.hdng_vld = d_vld;
    assign bus0.clr    = d_clr; assign bus0.err_sat  = d_err;
    assign bus1.moving = d_mv;  assign bus1.hdng_vld = d_vld;
    assign bus1.clr    = d_clr; assign bus1.err_sat  = d_err;
    assign bus2.moving = e_mv;  assign bus2.hdng_vld = e_vld;
    assign bus2.clr    = e_clr; assign bus2.err_sat  = e_err;

    integrator_gen2 #(.SAT_MODE(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    integrator_gen2 #(.SAT_MODE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    integrator_gen2 #(.LEAK_SHIFT(2), .LEAK_PERIOD(4), .SETTLE(0))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic       mv, vld, clr;
        logic [9:0] err;
        logic [11:0] it;
        logic       iv, st;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input int d, input logic [11:0] act, input logic [11:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h", name, d, act, exp);
    endtask

    task automatic check_dut(input int d, input string tag,
                             input logic [11:0] e_it, input logic e_iv, input logic e_st);
        logic [11:0] a_it;
        logic        a_iv, a_st;
        case (d)
            0:       begin a_it = bus0.I_term; a_iv = bus0.I_vld; a_st = bus0.sat; end
            1:       begin a_it = bus1.I_term; a_iv = bus1.I_vld; a_st = bus1.sat; end
            default: begin a_it = bus2.I_term; a_iv = bus2.I_vld; a_st = bus2.sat; end
        endcase
        chk({tag, ".I_term"}, d, a_it, e_it);
        chk({tag, ".I_vld"},  d, {11'd0, a_iv}, {11'd0, e_iv});
        chk({tag, ".sat"},    d, {11'd0, a_st}, {11'd0, e_st});
        $display("txn %s dut%0d: I_term=0x%03h I_vld=%0b sat=%0b", tag, d, a_it, a_iv, a_st);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leave IDLE and sit out the 8-cycle settle window with no samples.
    task automatic settle_d();
        d_mv = 1'b0; d_vld = 1'b0; d_clr = 1'b0;
        tick();
        d_mv = 1'b1;
        repeat (9) tick();
    endtask

    logic [11:0] leak_exp [8];

    initial begin
        // mv vld clr err      I_term  iv st
        tbl[0]  = '{1, 1, 0, 10'h200, 12'hFE0, 1, 0};  // -512 from 0
        tbl[1]  = '{1, 1, 0, 10'h1FF, 12'hFFF, 1, 0};  // -> -1
        tbl[2]  = '{1, 0, 0, 10'h1FF, 12'hFFF, 0, 0};  // no sample: hold
        tbl[3]  = '{1, 1, 0, 10'h001, 12'h000, 1, 0};  // -> 0
        tbl[4]  = '{1, 1, 1, 10'h100, 12'h000, 0, 0};  // clr beats sample
        tbl[5]  = '{1, 1, 0, 10'h100, 12'h010, 1, 0};  // still RUN after clr
        tbl[6]  = '{1, 0, 1, 10'h000, 12'h000, 0, 0};  // clr alone
        tbl[7]  = '{1, 1, 0, 10'h0F0, 12'h00F, 1, 0};
        tbl[8]  = '{1, 1, 0, 10'h3FF, 12'h00E, 1, 0};  // 0xF0 - 1 = 0xEF
        tbl[9]  = '{0, 1, 0, 10'h100, 12'h000, 0, 0};  // moving=0 beats sample
        tbl[10] = '{1, 1, 0, 10'h100, 12'h000, 0, 0};  // IDLE ignores sample
        leak_exp = '{12'h004, 12'h008, 12'h00C, 12'h00C, 12'h010, 12'h014, 12'h018, 12'h015};

        rst = 1'b1;
        d_mv = 0; d_vld = 0; d_clr = 0; d_err = '0;
        e_mv = 0; e_vld = 0; e_clr = 0; e_err = '0;
        #12;
        for (int d = 0; d < 3; d++) check_dut(d, "reset", 12'h000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Settle window: IDLE edge plus 8 SETTLE edges ignore samples.
        d_mv = 1'b1; d_vld = 1'b1; d_err = 10'h010;
        for (int k = 0; k < 9; k++) begin
            tick();
            check_dut(0, "settle", 12'h000, 1'b0, 1'b0);
        end
        tick(); check_dut(0, "first_run", 12'h001, 1'b1, 1'b0);
        tick(); check_dut(0, "second_run", 12'h002, 1'b1, 1'b0);
        d_err = 10'h103;
        tick(); check_dut(0, "acc_0123", 12'h012, 1'b1, 1'b0);

        // Asynchronous reset between edges takes effect at once.
        #2 rst = 1'b1;
        #1 check_dut(0, "async_rst", 12'h000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Table of single-edge vectors, checked on both overflow variants.
        settle_d();
        for (int i = 0; i < 11; i++) begin
            d_mv = tbl[i].mv; d_vld = tbl[i].vld; d_clr = tbl[i].clr; d_err = tbl[i].err;
            tick();
            check_dut(0, $sformatf("vec%0d", i), tbl[i].it, tbl[i].iv, tbl[i].st);
            check_dut(1, $sformatf("vec%0d", i), tbl[i].it, tbl[i].iv, tbl[i].st);
        end

        // Positive overflow: hold vs clamp.
        settle_d();
        d_vld = 1'b1; d_err = 10'h1FF;
        repeat (64) tick();
        d_err = 10'h030;
        tick();
        check_dut(0, "acc_7ff0", 12'h7FF, 1'b1, 1'b0);
        check_dut(1, "acc_7ff0", 12'h7FF, 1'b1, 1'b0);
        d_err = 10'h1FF;
        tick();
        check_dut(0, "pos_ov", 12'h7FF, 1'b1, 1'b1);
        check_dut(1, "pos_ov", 12'h7FF, 1'b1, 1'b1);
        d_err = 10'h3F1;  // -15: hold gives 0x7FE1, clamp gives 0x7FF0
        tick();
        check_dut(0, "after_ov", 12'h7FE, 1'b1, 1'b0);
        check_dut(1, "after_ov", 12'h7FF, 1'b1, 1'b0);
        d_err = 10'h00F;
        tick();
        check_dut(1, "exact_max", 12'h7FF, 1'b1, 1'b0);
        d_err = 10'h001;
        tick();
        check_dut(0, "max_plus1", 12'h7FF, 1'b1, 1'b0);
        check_dut(1, "max_plus1", 12'h7FF, 1'b1, 1'b1);
        d_vld = 1'b0;
        tick();
        check_dut(1, "sat_holds", 12'h7FF, 1'b0, 1'b1);

        // Negative side: reach exactly the minimum, then one more step.
        d_clr = 1'b1;
        tick();
        check_dut(1, "clr", 12'h000, 1'b0, 1'b0);
        d_clr = 1'b0; d_vld = 1'b1; d_err = 10'h200;
        repeat (64) tick();
        check_dut(0, "exact_min", 12'h800, 1'b1, 1'b0);
        check_dut(1, "exact_min", 12'h800, 1'b1, 1'b0);
        d_err = 10'h3FF;
        tick();
        check_dut(0, "neg_ov", 12'h800, 1'b1, 1'b1);
        check_dut(1, "neg_ov", 12'h800, 1'b1, 1'b1);
        d_mv = 1'b0;
        tick();
        check_dut(0, "stop_moving", 12'h000, 1'b0, 1'b0);

        // Leak instance: SETTLE=0, leak by 1/4 every 4th sample.
        e_mv = 1'b1;
        tick();
        e_vld = 1'b1; e_err = 10'h040;
        for (int k = 0; k < 8; k++) begin
            tick();
            check_dut(2, $sformatf("leak%0d", k), leak_exp[k], 1'b1, 1'b0);
        end
        e_clr = 1'b1;
        tick();
        check_dut(2, "leak_clr", 12'h000, 1'b0, 1'b0);
        e_clr = 1'b0; e_err = 10'h000;
        repeat (3) tick();
        e_err = 10'h3FF;
        tick();
        check_dut(2, "leak_m1", 12'h000, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
